// File: rtl/ssd1306_pkg.sv
// ============================================================================
// Module      : ssd1306_pkg
// Description : Shared types and constants for the SSD1306 OLED SPI path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ssd1306_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        GAP  = 2'd3
    } spi_state_t;

    localparam int SSD1306_SPI_DEFAULT_DIV = 2;

endpackage

`default_nettype wire

// File: rtl/ssd1306_half_period_timer.sv
// ============================================================================
// Module      : ssd1306_half_period_timer
// Description : Loadable down-counter; load sets CLK_DIV-1, zero flags 0.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ssd1306_half_period_timer #(
    parameter int CLK_DIV = 2
) (
    input  logic clk_in,
    input  logic reset,
    input  logic load,
    output logic zero
);

    localparam int              c_W      = $clog2(CLK_DIV + 1);
    localparam logic [c_W-1:0]  c_RELOAD = c_W'(CLK_DIV - 1);

    logic [c_W-1:0] r_count;

    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= c_RELOAD;
        end else if (r_count != '0) begin
            r_count <= r_count - c_W'(1);
        end
    end

    assign zero = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/ssd1306_spi_shifter.sv
// ============================================================================
// Module      : ssd1306_spi_shifter
// Description : Byte-wide SPI mode-0 MSB-first transmitter with ready/start
//               handshake; all outputs registered.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ssd1306_spi_shifter
    import ssd1306_pkg::*;
#(
    parameter int CLK_DIV = SSD1306_SPI_DEFAULT_DIV
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic       command_start,
    input  logic [7:0] command_in,
    output logic       command_ready,
    output logic       spi_sclk,
    output logic       spi_mosi,
    output logic       spi_busy
);

    localparam logic [1:0] c_ST_IDLE = IDLE;
    localparam logic [1:0] c_ST_LOW  = LOW;
    localparam logic [1:0] c_ST_HIGH = HIGH;
    localparam logic [1:0] c_ST_GAP  = GAP;

    logic [1:0] r_state;
    logic [7:0] r_shift;
    logic [2:0] r_bit_cnt;
    logic       r_ready;
    logic       r_busy;
    logic       r_sclk;
    logic       r_mosi;
    logic       w_zero;
    logic       w_load;

    // The timer is only rearmed when entering a timed phase; it rests at 0 in IDLE.
    assign w_load = ((r_state == c_ST_IDLE) && command_start) ||
                    (((r_state == c_ST_LOW) || (r_state == c_ST_HIGH)) && w_zero);

    ssd1306_half_period_timer #(
        .CLK_DIV (CLK_DIV)
    ) u_timer (
        .clk_in (clk_in),
        .reset  (reset),
        .load   (w_load),
        .zero   (w_zero)
    );

    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_state   <= c_ST_IDLE;
            r_shift   <= 8'h00;
            r_bit_cnt <= 3'd0;
            r_ready   <= 1'b1;
            r_busy    <= 1'b0;
            r_sclk    <= 1'b0;
            r_mosi    <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (command_start) begin
                        r_shift   <= command_in;
                        r_bit_cnt <= 3'd7;
                        r_state   <= c_ST_LOW;
                        r_ready   <= 1'b0;
                        r_busy    <= 1'b1;
                        r_sclk    <= 1'b0;
                        r_mosi    <= command_in[7];
                    end
                end
                c_ST_LOW: begin
                    if (w_zero) begin
                        r_state <= c_ST_HIGH;
                        r_sclk  <= 1'b1;
                    end
                end
                c_ST_HIGH: begin
                    if (w_zero) begin
                        r_sclk <= 1'b0;
                        if (r_bit_cnt != 3'd0) begin
                            // MOSI moves with the falling edge so it is stable around each rise.
                            r_shift   <= {r_shift[6:0], 1'b0};
                            r_bit_cnt <= r_bit_cnt - 3'd1;
                            r_mosi    <= r_shift[6];
                            r_state   <= c_ST_LOW;
                        end else begin
                            r_state <= c_ST_GAP;
                        end
                    end
                end
                c_ST_GAP: begin
                    if (w_zero) begin
                        r_state <= c_ST_IDLE;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                        r_mosi  <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign command_ready = r_ready;
    assign spi_busy      = r_busy;
    assign spi_sclk      = r_sclk;
    assign spi_mosi      = r_mosi;

endmodule

`default_nettype wire

// File: tb/tb_ssd1306_spi_shifter.sv
// ============================================================================
// Module      : tb_ssd1306_spi_shifter
// Description : Directed self-checking bench; DUT0 uses CLK_DIV=2, DUT1 CLK_DIV=1.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ssd1306_spi_shifter;

    logic       clk_in = 1'b0;
    logic       reset  = 1'b1;
    logic [1:0] start  = 2'b00;
    logic [7:0] cmd0   = 8'h00;
    logic [7:0] cmd1   = 8'h00;
    logic [1:0] ready;
    logic [1:0] sclk;
    logic [1:0] mosi;
    logic [1:0] busy;
    int         total  = 0;
    int         bad    = 0;
    int         ptr;

    always #5 clk_in = ~clk_in;

    ssd1306_spi_shifter #(.CLK_DIV(2)) u_dut0 (
        .clk_in        (clk_in),
        .reset         (reset),
        .command_start (start[0]),
        .command_in    (cmd0),
        .command_ready (ready[0]),
        .spi_sclk      (sclk[0]),
        .spi_mosi      (mosi[0]),
        .spi_busy      (busy[0])
    );

    ssd1306_spi_shifter #(.CLK_DIV(1)) u_dut1 (
        .clk_in        (clk_in),
        .reset         (reset),
        .command_start (start[1]),
        .command_in    (cmd1),
        .command_ready (ready[1]),
        .spi_sclk      (sclk[1]),
        .spi_mosi      (mosi[1]),
        .spi_busy      (busy[1])
    );

    // Upstream-style pointer advancing on every handshake of DUT0.
    always @(posedge clk_in) begin
        if (reset)
            ptr <= 0;
        else if (start[0] && ready[0])
            ptr <= ptr + 1;
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input int d, input logic s, input logic [7:0] b);
        start[d] = s;
        if (d == 0) cmd0 = b;
        else        cmd1 = b;
    endtask

    // Starts in a cycle where DUT d is ready; returns in cycle 17*div+1.
    task automatic xfer(input int d, input logic [7:0] b, input bit hold,
                        input int pulse_cyc, input logic [7:0] pulse_b);
        int         div;
        int         edges;
        logic       prev_sclk;
        logic [7:0] rx;
        div       = (d == 0) ? 2 : 1;
        edges     = 0;
        prev_sclk = 1'b0;
        rx        = 8'h00;
        set_in(d, 1'b1, b);
        tick();
        if (!hold) set_in(d, 1'b0, b);
        for (int c = 1; c <= 17 * div; c++) begin
            check($sformatf("d%0d_%02h_ready_c%0d", d, b, c), 32'(ready[d]), 32'd0);
            if (c <= 16 * div) begin
                check($sformatf("d%0d_%02h_sclk_c%0d", d, b, c), 32'(sclk[d]),
                      32'(((c - 1) / div) % 2));
                check($sformatf("d%0d_%02h_mosi_c%0d", d, b, c), 32'(mosi[d]),
                      32'(b[7 - ((c - 1) / (2 * div))]));
            end else begin
                check($sformatf("d%0d_%02h_gap_sclk_c%0d", d, b, c), 32'(sclk[d]), 32'd0);
                check($sformatf("d%0d_%02h_gap_mosi_c%0d", d, b, c), 32'(mosi[d]), 32'(b[0]));
            end
            if (sclk[d] && !prev_sclk) begin
                edges++;
                rx = {rx[6:0], mosi[d]};
            end
            prev_sclk = sclk[d];
            if (pulse_cyc != 0 && c == pulse_cyc)     set_in(d, 1'b1, pulse_b);
            if (pulse_cyc != 0 && c == pulse_cyc + 1) set_in(d, 1'b0, pulse_b);
            tick();
        end
        check($sformatf("d%0d_%02h_ready_end", d, b), 32'(ready[d]), 32'd1);
        check($sformatf("d%0d_%02h_busy_end", d, b), 32'(busy[d]), 32'd0);
        check($sformatf("d%0d_%02h_sclk_end", d, b), 32'(sclk[d]), 32'd0);
        check($sformatf("d%0d_%02h_mosi_end", d, b), 32'(mosi[d]), 32'd0);
        check($sformatf("d%0d_%02h_edges", d, b), 32'(edges), 32'd8);
        check($sformatf("d%0d_%02h_rx", d, b), 32'(rx), 32'(b));
    endtask

    initial begin
        int p0;
        // Reset values
        repeat (3) tick();
        for (int d = 0; d < 2; d++) begin
            check($sformatf("rst_ready%0d", d), 32'(ready[d]), 32'd1);
            check($sformatf("rst_busy%0d", d),  32'(busy[d]),  32'd0);
            check($sformatf("rst_sclk%0d", d),  32'(sclk[d]),  32'd0);
            check($sformatf("rst_mosi%0d", d),  32'(mosi[d]),  32'd0);
        end
        reset = 1'b0;

        // Idle quiet for 100 cycles
        for (int i = 0; i < 100; i++) begin
            check($sformatf("idle_ready_%0d", i), 32'(ready[0]), 32'd1);
            check($sformatf("idle_sclk_%0d", i),  32'(sclk[0]),  32'd0);
            tick();
        end

        // Single byte at CLK_DIV=2
        xfer(0, 8'hAE, 1'b0, 0, 8'h00);
        tick();

        // Back-to-back with start held high
        p0 = ptr;
        xfer(0, 8'hA5, 1'b1, 0, 8'h00);
        xfer(0, 8'h5A, 1'b1, 0, 8'h00);
        set_in(0, 1'b0, 8'h00);
        repeat (5) tick();
        check("b2b_ptr_delta", 32'(ptr - p0), 32'd2);
        check("b2b_ready_after", 32'(ready[0]), 32'd1);

        // CLK_DIV=1
        xfer(1, 8'hFF, 1'b0, 0, 8'h00);
        xfer(1, 8'h00, 1'b0, 0, 8'h00);

        // Start pulsed while busy is ignored
        tick();
        xfer(0, 8'h3C, 1'b0, 12, 8'h81);
        repeat (3) tick();
        check("ignore_ready", 32'(ready[0]), 32'd1);
        check("ignore_sclk",  32'(sclk[0]),  32'd0);

        // Reset at cycle 10 of a 0xC8 transfer
        set_in(0, 1'b1, 8'hC8);
        tick();
        set_in(0, 1'b0, 8'hC8);
        repeat (9) tick();
        check("c8_busy_c10", 32'(busy[0]), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_sclk",  32'(sclk[0]),  32'd0);
        check("abort_mosi",  32'(mosi[0]),  32'd0);
        check("abort_ready", 32'(ready[0]), 32'd1);
        check("abort_busy",  32'(busy[0]),  32'd0);
        xfer(0, 8'h20, 1'b0, 0, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
